// File: rtl/const_rom_arbiter_pkg.sv
// Shared types and defaults for the constRom arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package const_rom_arb_pkg;

    localparam int ADDR_W = 6;   // constRom address width (64 words)
    localparam int DATA_W = 32;  // constRom word width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Requester id: 0 or 1.
    typedef logic owner_t;

endpackage

// File: rtl/const_rom_arbiter_if.sv
// Bundle of requester, ROM and output-stream signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer; req held until gnt.
// Modports: slave = arbiter side, master = requesters/ROM/consumer side.
interface const_rom_arbiter_if #(
    parameter int ADDR_W = const_rom_arb_pkg::ADDR_W,
    parameter int DATA_W = const_rom_arb_pkg::DATA_W
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] base1;
    logic [ADDR_W-1:0] len0;
    logic [ADDR_W-1:0] len1;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_read;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_id;
    logic              out_last;

    modport slave (
        input  req, base0, base1, len0, len1, rom_data, out_ready,
        output gnt, rom_addr, rom_read, out_data, out_valid, out_id, out_last
    );

    modport master (
        output req, base0, base1, len0, len1, rom_data, out_ready,
        input  gnt, rom_addr, rom_read, out_data, out_valid, out_id, out_last
    );
endinterface

// File: rtl/const_rom_arbiter_rr_pick2.sv
// Two-way round-robin selector: picks the requester that did not go last.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req[1:0] requests, last_owner previous winner -> any, owner.
module rr_pick2
    import const_rom_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       any,
    output owner_t     owner
);
    assign any = |req;

    // With both asking, alternate away from the last owner; otherwise the
    // single asker wins (req[1] alone -> 1, req[0] alone -> 0).
    assign owner = (req == 2'b11) ? ~last_owner : req[1];
endmodule

// File: rtl/const_rom_arbiter.sv
// Shares constRom between two burst requesters, streaming words out tagged with id/last.
// Latency: gnt one cycle after req seen in IDLE, first word valid one cycle after gnt; 2 cycles/word.
// Backpressure: out_ready low holds the word in HOLD; ROM address does not advance meanwhile.
// Ports: clk, rst_n (async active-low), bus (slave modport: req/base/len in, gnt out,
//        rom_addr/rom_read out, rom_data in, out_data/out_valid/out_id/out_last out, out_ready in).
module const_rom_arbiter
    import const_rom_arb_pkg::*;
#(
    parameter int ADDR_W = const_rom_arb_pkg::ADDR_W,
    parameter int DATA_W = const_rom_arb_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    const_rom_arbiter_if.slave bus
);
    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic              r_read;
    logic [1:0]        r_gnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    owner_t            r_id;
    logic              r_last;
    owner_t            r_last_owner;

    logic   w_any;
    owner_t w_owner;
    logic   w_grant;
    logic   w_capture;
    logic   w_accept;

    rr_pick2 u_pick (
        .req        (bus.req),
        .last_owner (r_last_owner),
        .any        (w_any),
        .owner      (w_owner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nx = ST_ISSUE;
            ST_ISSUE: w_state_nx = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) w_state_nx = r_last ? ST_IDLE : ST_ISSUE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_grant   = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            ST_IDLE:  w_grant   = w_any;
            ST_ISSUE: w_capture = 1'b1;
            // out_valid is always 1 in HOLD, so ready alone is the accept
            ST_HOLD:  w_accept  = bus.out_ready;
            default:  ;
        endcase
    end

    // Datapath: address/remaining counters and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_remaining  <= '0;
            r_read       <= 1'b0;
            r_gnt        <= 2'b00;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_id         <= 1'b0;
            r_last       <= 1'b0;
            r_last_owner <= 1'b1;  // requester 0 wins the first tie
        end else begin
            r_gnt <= 2'b00;
            if (w_grant) begin
                // base/len sampled only here; later input changes are ignored
                r_addr         <= w_owner ? bus.base1 : bus.base0;
                r_remaining    <= w_owner ? bus.len1  : bus.len0;
                r_id           <= w_owner;
                r_gnt[w_owner] <= 1'b1;
                r_read         <= 1'b1;
            end
            if (w_capture) begin
                r_data  <= bus.rom_data;
                r_valid <= 1'b1;
                r_last  <= (r_remaining == '0);
            end
            if (w_accept) begin
                r_valid <= 1'b0;
                if (r_last) begin
                    r_read       <= 1'b0;
                    r_last_owner <= r_id;
                end else begin
                    r_addr      <= r_addr + 1'b1;  // wraps 63 -> 0
                    r_remaining <= r_remaining - 1'b1;
                end
            end
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rom_addr  = r_addr;
    assign bus.rom_read  = r_read;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_id    = r_id;
    assign bus.out_last  = r_last;
endmodule
